// File: rtl/wired_bus_pkg.sv
// Shared types and helpers for the wired/tri-state bus arbiter.
package wired_bus_pkg;

  localparam int TURN_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_t;

  // Increment modulo n without relying on n being a power of two.
  function automatic int unsigned next_idx(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/wired_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible index at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    index
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        index      = idx;
      end
    end
  end

endmodule

// File: rtl/wired_bus_arbiter.sv
// Arbiter for a shared wired net: one strong driver at a time, with idle
// turnaround between owners, hold-time limit and post-timeout lockout.
module wired_bus_arbiter
  import wired_bus_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         oe,
  output logic                     bus_idle,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [HW-1:0]     hold_cnt;
  logic [TURN_W-1:0] turn_cnt;
  logic [N_REQ-1:0]  lockout;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;

  assign eligible = req & ~lockout;
  assign oe       = gnt;
  assign bus_idle = ~|gnt;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (pick_gnt),
    .index    (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      owner_id    <= '0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
      turn_cnt    <= '0;
      lockout     <= '0;
    end else begin
      timeout_err <= 1'b0;
      // A lockout bit only survives while its requester keeps req high.
      lockout     <= lockout & req;
      case (state)
        IDLE: begin
          if (|eligible) begin
            gnt      <= pick_gnt;
            owner_id <= pick_idx;
            hold_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          hold_cnt <= hold_cnt + HW'(1);
          if (!req[owner_id] || hold_cnt == HOLD_LAST) begin
            gnt <= '0;
            ptr <= IW'(next_idx(32'(owner_id), N_REQ));
            if (req[owner_id]) begin
              timeout_err <= 1'b1;
              lockout     <= (lockout & req) | (ONE << owner_id);
            end
            if (TURN_CYC == 0) begin
              state <= IDLE;
            end else begin
              state    <= TURN;
              turn_cnt <= TURN_W'(TURN_CYC);
            end
          end
        end
        TURN: begin
          turn_cnt <= turn_cnt - TURN_W'(1);
          if (turn_cnt <= TURN_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Directed bench: default instance (TURN_CYC=1, MAX_HOLD=16) plus a TURN_CYC=0 instance.
module tb_wired_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, oe_a, gnt_b, oe_b;
  logic       idle_a, idle_b, te_a, te_b;
  logic [1:0] oid_a, oid_b;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wired_bus_arbiter #(.N_REQ(4), .TURN_CYC(1), .MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .oe(oe_a),
    .bus_idle(idle_a), .owner_id(oid_a), .timeout_err(te_a)
  );

  wired_bus_arbiter #(.N_REQ(4), .TURN_CYC(0), .MAX_HOLD(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .oe(oe_b),
    .bus_idle(idle_b), .owner_id(oid_b), .timeout_err(te_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req_a = r;
    req_b = 4'b0000;
    #4;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_a = 4'b1111;
    req_b = 4'b0000;
    tick();
    checks++; if (gnt_a !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b want=0000", gnt_a); end
    checks++; if (oe_a !== 4'b0000) begin failures++; $display("FAIL reset_oe got=%b want=0000", oe_a); end
    checks++; if (idle_a !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b want=1", idle_a); end
    checks++; if (oid_a !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d want=0", oid_a); end
    checks++; if (te_a !== 1'b0) begin failures++; $display("FAIL reset_te got=%b want=0", te_a); end
    rst_n = 1'b1;
    tick();
    checks++; if (gnt_a !== 4'b0001) begin failures++; $display("FAIL reset_first_gnt got=%b want=0001", gnt_a); end
    checks++; if (idle_a !== 1'b0) begin failures++; $display("FAIL reset_first_idle got=%b want=0", idle_a); end
    $display("reset: gnt=%b oe=%b bus_idle=%b", gnt_a, oe_a, idle_a);
  endtask

  task automatic test_round_robin;
    logic [3:0] one;
    logic [3:0] exp;
    one = 4'b0001;
    for (int j = 0; j < 5; j++) begin
      exp = one << (j % 4);
      for (int h = 0; h < 3; h++) begin
        checks++;
        if (gnt_a !== exp || oe_a !== exp) begin
          failures++;
          $display("FAIL rr_hold j=%0d h=%0d got gnt=%b oe=%b want=%b", j, h, gnt_a, oe_a, exp);
        end
        if (h < 2) tick();
      end
      checks++; if (oid_a !== 2'(j % 4)) begin failures++; $display("FAIL rr_owner j=%0d got=%0d want=%0d", j, oid_a, j % 4); end
      req_a = req_a & ~exp;
      tick();
      checks++; if (gnt_a !== 4'b0000 || idle_a !== 1'b1) begin failures++; $display("FAIL rr_turn j=%0d got gnt=%b idle=%b want=0000/1", j, gnt_a, idle_a); end
      req_a = 4'b1111;
      tick();
      checks++; if (gnt_a !== 4'b0000) begin failures++; $display("FAIL rr_idle j=%0d got=%b want=0000", j, gnt_a); end
      tick();
      $display("rr: owner %0d released, next gnt=%b", j % 4, gnt_a);
    end
  endtask

  task automatic test_timeout;
    do_reset(4'b0100);
    tick();
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (gnt_a !== 4'b0100 || te_a !== 1'b0) begin
        failures++;
        $display("FAIL to_hold n=%0d got gnt=%b te=%b want=0100/0", n, gnt_a, te_a);
      end
      tick();
    end
    checks++; if (gnt_a !== 4'b0000 || te_a !== 1'b1) begin failures++; $display("FAIL to_release got gnt=%b te=%b want=0000/1", gnt_a, te_a); end
    tick();
    checks++; if (te_a !== 1'b0) begin failures++; $display("FAIL to_pulse_len got te=%b want=0", te_a); end
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++; if (gnt_a !== 4'b0000) begin failures++; $display("FAIL to_lockout n=%0d got=%b want=0000", n, gnt_a); end
    end
    req_a = 4'b0000;
    tick();
    checks++; if (gnt_a !== 4'b0000) begin failures++; $display("FAIL to_dropped got=%b want=0000", gnt_a); end
    req_a = 4'b0100;
    tick();
    checks++; if (gnt_a !== 4'b0100) begin failures++; $display("FAIL to_regrant got=%b want=0100", gnt_a); end
    $display("timeout: regrant after req drop gnt=%b", gnt_a);
  endtask

  task automatic test_same_cycle;
    do_reset(4'b0010);
    tick();
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (gnt_a !== 4'b0010) begin failures++; $display("FAIL sc_hold n=%0d got=%b want=0010", n, gnt_a); end
      if (n == 15) req_a = 4'b0000;
      tick();
    end
    checks++; if (gnt_a !== 4'b0000 || te_a !== 1'b0) begin failures++; $display("FAIL sc_release got gnt=%b te=%b want=0000/0", gnt_a, te_a); end
    req_a = 4'b0010;
    tick();
    checks++; if (gnt_a !== 4'b0000 || te_a !== 1'b0) begin failures++; $display("FAIL sc_turn got gnt=%b te=%b want=0000/0", gnt_a, te_a); end
    tick();
    checks++; if (gnt_a !== 4'b0010) begin failures++; $display("FAIL sc_no_lockout got=%b want=0010", gnt_a); end
    $display("same_cycle: regrant gnt=%b", gnt_a);
  endtask

  task automatic test_turn_zero;
    do_reset(4'b0000);
    req_b = 4'b0011;
    tick();
    checks++; if (gnt_b !== 4'b0001) begin failures++; $display("FAIL tz_first got=%b want=0001", gnt_b); end
    tick();
    checks++; if (gnt_b !== 4'b0001) begin failures++; $display("FAIL tz_hold got=%b want=0001", gnt_b); end
    req_b = 4'b0010;
    tick();
    checks++; if (gnt_b !== 4'b0000 || idle_b !== 1'b1) begin failures++; $display("FAIL tz_gap got gnt=%b idle=%b want=0000/1", gnt_b, idle_b); end
    tick();
    checks++; if (gnt_b !== 4'b0010 || oe_b !== 4'b0010) begin failures++; $display("FAIL tz_next got gnt=%b oe=%b want=0010", gnt_b, oe_b); end
    checks++; if ($countones(oe_b) > 1) begin failures++; $display("FAIL tz_onehot got=%b want=at most one bit", oe_b); end
    $display("turn_zero: gnt=%b", gnt_b);
  endtask

  task automatic test_async_reset;
    do_reset(4'b0100);
    tick();
    checks++; if (gnt_a !== 4'b0100) begin failures++; $display("FAIL ar_setup got=%b want=0100", gnt_a); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (oe_a !== 4'b0000 || gnt_a !== 4'b0000) begin failures++; $display("FAIL ar_oe got oe=%b gnt=%b want=0000", oe_a, gnt_a); end
    checks++; if (idle_a !== 1'b1 || oid_a !== 2'd0) begin failures++; $display("FAIL ar_state got idle=%b owner=%0d want=1/0", idle_a, oid_a); end
    tick();
    rst_n = 1'b1;
    req_a = 4'b0000;
    $display("async_reset: oe=%b after mid-cycle reset", oe_a);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_same_cycle();
    test_turn_zero();
    test_async_reset();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wired_bus_arbiter.md
Name: wired_bus_arbiter

Overview:
- Shares one wired/tri-state net among N_REQ requesters.
- At most one requester strong-drives the net at any time.
- Between owners, no driver is enabled for TURN_CYC cycles, so the net settles to its pull/keeper level before the next owner drives.
- Sits between requester logic and the per-requester tri-state drivers (oe) of the shared net.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TURN_CYC, 1, idle turnaround cycles between owners (0..15). 0 means no turnaround.
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the net (2..256).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  request per requester; held high for as long as ownership is wanted.
- gnt  out  N_REQ  one-hot grant, or all zero.
- oe  out  N_REQ  strong drive enable to each requester's tri-state driver; always equals gnt.
- bus_idle  out  1  high when no oe is asserted (net left to pull/keeper).
- owner_id  out  clog2(N_REQ)  index of the current/last owner.
- timeout_err  out  1  one-cycle pulse when an owner is forcibly released.

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, oe=0, bus_idle=1, owner_id=0, timeout_err=0.
  - Round-robin pointer ptr=0, hold_cnt=0, turn_cnt=0, lockout=0, state=IDLE.
- Eligibility: eligible = req & ~lockout.
- States are IDLE, OWN and TURN.
- IDLE:
  - If eligible != 0, pick the first eligible index at or after ptr, wrapping modulo N_REQ.
  - Next cycle: gnt/oe assert for that index, owner_id updates, hold_cnt=0, state=OWN.
  - Latency from req rise to gnt: 1 cycle.
- OWN:
  - hold_cnt increments each cycle.
  - If req[owner] is low: gnt/oe drop next cycle, ptr = owner+1 (mod N_REQ), turn_cnt = TURN_CYC, state=TURN. If TURN_CYC=0, go to IDLE instead.
  - Else if hold_cnt == MAX_HOLD-1 (forced release): gnt/oe drop next cycle, timeout_err pulses in that same cycle, lockout[owner]=1, ptr = owner+1, state=TURN (or IDLE if TURN_CYC=0).
  - Net result: an owner holds for at most MAX_HOLD cycles.
- TURN:
  - gnt=0, oe=0, bus_idle=1.
  - turn_cnt decrements each cycle; on reaching 1, state=IDLE.
  - The net is undriven for exactly TURN_CYC cycles.
  - Requests arriving during TURN are not granted until IDLE.
- Lockout:
  - lockout[i] clears in any cycle where req[i] is low.
  - A timed-out requester must drop req for at least one cycle before it can win again.
- Invariants:
  - oe is always one-hot or zero.
  - gnt never moves directly from one owner to another. Between two different owners there are ≥ TURN_CYC cycles, plus one IDLE arbitration cycle, with oe=0.
  - bus_idle == ~|oe.
- Owner re-request: the owner may win again after release only if no other requester is eligible. Because ptr has advanced, round-robin fairness holds.
- Simultaneous events:
  - Owner drops req in the same cycle hold_cnt hits MAX_HOLD-1: treated as normal release. No timeout_err, no lockout.
  - Multiple requesters rising together: round-robin from ptr.
- Reset mid-operation: oe drops immediately (asynchronous), all state returns to reset values.
- Width rules:
  - hold_cnt width = clog2(MAX_HOLD).
  - turn_cnt width = 4 bits.
  - ptr width = clog2(N_REQ).
  - ptr wrap computed modulo N_REQ, correct for non-power-of-2 N_REQ.

Decomposition:
- Shared package wired_bus_pkg holds:
  - state enum: IDLE, OWN, TURN.
  - Turnaround counter width constant (4).
  - Helper function for the modulo-N_REQ increment.
- One sub-module, rr_pick: combinational round-robin priority pick.
  - Inputs: eligible vector, ptr.
  - Outputs: one-hot grant and index.
- The FSM, counters and lockout stay in wired_bus_arbiter.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 -> gnt=0, oe=0, bus_idle=1, owner_id=0. Release rst_n -> gnt=4'b0001 one cycle later.
- Round-robin: req=4'b1111, each owner holds 3 cycles then drops and re-raises. With TURN_CYC=1, gnt sequence is 0001,0010,0100,1000,0001, with exactly 1 oe=0 cycle plus 1 IDLE cycle between owners.
- Timeout: MAX_HOLD=16, req[2] held high alone. gnt[2] lasts exactly 16 cycles, timeout_err pulses once, and gnt[2] is not reasserted until req[2] goes low for ≥1 cycle and rises again.
- Same-cycle release and limit: req[1] drops exactly when hold_cnt=15 -> no timeout_err, lockout[1] stays 0.
- Turnaround zero: TURN_CYC=0, req=4'b0011 with owner 0 dropping -> gnt goes 0001 -> 0000 (1 IDLE cycle) -> 0010. oe is never two-hot.
- Async reset mid-OWN: assert rst_n low between clock edges while gnt=4'b0100 -> oe=0 immediately, with no clock edge needed.
